// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling,
// a one-cycle data-valid strobe and a separate framing-error strobe.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          s1_q, s2_q;
    logic          rx_s;

    assign rx_s          = s2_q;
    assign rx_data       = data_q;
    assign rx_data_valid = valid_q;
    assign frame_err     = ferr_q;
    assign busy          = state_q != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            s1_q    <= rx;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt_q == LAST) begin
                cnt_d   = '0;
                shift_d = {rx_s, shift_q[7:1]};
                idx_d   = idx_q + 1'b1;
                if (idx_q == 3'd7) state_d = STOP;
            end
            STOP: if (cnt_q == LAST) begin
                cnt_d   = '0;
                valid_d = rx_s;
                ferr_d  = !rx_s;
                data_d  = rx_s ? shift_q : data_q;
                state_d = rx_s ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                // a held-low line must return high before a new start edge counts
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
